// File: rtl/conv_decoder_par_if.sv
// FIFO-side and output-stream signals of the parallel convolutional decoder.
// master = decoder side, slave = FIFO / downstream side.
interface conv_decoder_par_if;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       empty0;
    logic       empty1;
    logic       empty2;
    logic       rdreq_subblock;
    logic       out_full;
    logic [0:7] data_out;
    logic       data_out_valid;

    modport master (
        input  q0, q1, q2, empty0, empty1, empty2, out_full,
        output rdreq_subblock, data_out, data_out_valid
    );

    modport slave (
        output q0, q1, q2, empty0, empty1, empty2, out_full,
        input  rdreq_subblock, data_out, data_out_valid
    );
endinterface

// File: rtl/conv_decoder_par.sv
// Tail-biting rate-1/3 K=7 convolutional decoder, 8 information bits per cycle.
// Inverts the g0=133 stream directly and re-encodes with 171/165 to count code-bit errors.
module conv_decoder_par (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   code_block_length,
    input  logic [0:7]             tail_byte,
    conv_decoder_par_if.master     bus,
    output logic [15:0]            err_count,
    output logic                   tail_err,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e      st_q, st_d;
    logic        len_q, len_d;
    logic [5:0]  tail_q, tail_d;
    logic [5:0]  hist_q, hist_d;   // hist[k] = x_{-1-k}
    logic [5:0]  init_q, init_d;
    logic [9:0]  req_cnt_q, req_cnt_d;
    logic [9:0]  wr_cnt_q, wr_cnt_d;
    logic        rd_vld_q, rd_vld_d;
    logic [0:7]  dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic [15:0] err_q, err_d;
    logic        tail_err_q, tail_err_d;
    logic        done_q, done_d;

    logic [9:0]  last_idx;
    logic        rdreq;
    logic [13:0] x;                // x[t+6] = x_t for t = -6..7
    logic [0:7]  u;
    logic [7:0]  e1, e2;
    logic [4:0]  n_err;
    logic [16:0] err_sum;
    logic        unused_tail;

    assign unused_tail = ^tail_byte[0:1];
    assign last_idx    = len_q ? 10'd767 : 10'd131;

    always_comb begin
        x     = '0;
        u     = '0;
        e1    = '0;
        e2    = '0;
        n_err = '0;
        for (int k = 0; k < 6; k++) begin
            x[k] = hist_q[5-k];
        end
        for (int j = 0; j < 8; j++) begin
            u[j]   = bus.q0[j] ^ x[j+4] ^ x[j+3] ^ x[j+1] ^ x[j];
            x[j+6] = u[j];
            e1[j]  = bus.q1[j] ^ u[j] ^ x[j+5] ^ x[j+4] ^ x[j+3] ^ x[j];
            e2[j]  = bus.q2[j] ^ u[j] ^ x[j+5] ^ x[j+4] ^ x[j+2] ^ x[j];
            n_err  = n_err + 5'(e1[j]) + 5'(e2[j]);
        end
        err_sum = {1'b0, err_q} + {12'd0, n_err};
    end

    always_comb begin
        st_d       = st_q;
        len_d      = len_q;
        tail_d     = tail_q;
        hist_d     = hist_q;
        init_d     = init_q;
        req_cnt_d  = req_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rd_vld_d   = 1'b0;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        err_d      = err_q;
        tail_err_d = tail_err_q;
        done_d     = 1'b0;
        rdreq      = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start) begin
                    len_d = code_block_length;
                    for (int k = 0; k < 6; k++) begin
                        tail_d[k] = tail_byte[7-k];
                    end
                    st_d = StLoad;
                end
            end
            StLoad: begin
                hist_d     = tail_q;
                init_d     = tail_q;
                req_cnt_d  = '0;
                wr_cnt_d   = '0;
                err_d      = '0;
                tail_err_d = 1'b0;
                st_d       = StRun;
            end
            StRun: begin
                rdreq = ~bus.empty0 & ~bus.empty1 & ~bus.empty2 & ~bus.out_full &
                        (req_cnt_q <= last_idx);
                rd_vld_d = rdreq;
                if (rdreq) begin
                    req_cnt_d = req_cnt_q + 10'd1;
                end
                // q0..q2 belong to the read issued last cycle
                if (rd_vld_q) begin
                    dout_d     = u;
                    dout_vld_d = 1'b1;
                    for (int k = 0; k < 6; k++) begin
                        hist_d[k] = u[7-k];
                    end
                    err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
                    wr_cnt_d = wr_cnt_q + 10'd1;
                    if (wr_cnt_q == last_idx) begin
                        st_d = StDone;
                    end
                end
            end
            StDone: begin
                tail_err_d = (hist_q != init_q);
                done_d     = 1'b1;
                st_d       = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= StIdle;
            len_q      <= 1'b0;
            tail_q     <= '0;
            hist_q     <= '0;
            init_q     <= '0;
            req_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            rd_vld_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            err_q      <= '0;
            tail_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            len_q      <= len_d;
            tail_q     <= tail_d;
            hist_q     <= hist_d;
            init_q     <= init_d;
            req_cnt_q  <= req_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_vld_q   <= rd_vld_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            err_q      <= err_d;
            tail_err_q <= tail_err_d;
            done_q     <= done_d;
        end
    end

    assign bus.rdreq_subblock = rdreq;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dout_vld_q;
    assign err_count          = err_q;
    assign tail_err           = tail_err_q;
    assign done               = done_q;
    assign busy               = (st_q == StLoad) || (st_q == StRun);
endmodule
